// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour BCD clock set/tick controller.
package clock_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_CAPTURE,
        S_EDIT_HH,
        S_EDIT_MM,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HH   = 2'd1,
        FIELD_MM   = 2'd2
    } field_t;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_11 = 8'h11;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_59 = 8'h59;

    // Two-digit BCD +1 with carry from the units digit into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_time_step.sv
// Combinational one-step increment of the selected field of a 12-hour BCD time.
module bcd_time_step
    import clock_pkg::*;
(
    input  field_t      field,
    input  logic [7:0]  hh,
    input  logic [7:0]  mm,
    input  logic        pm,
    output logic [7:0]  next_hh,
    output logic [7:0]  next_mm,
    output logic        next_pm
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_hh = hh;
        next_mm = mm;
        next_pm = pm;
        case (field)
            FIELD_HH: begin
                if (hh == BCD_12) begin
                    next_hh = BCD_01;
                end else if (hh == BCD_11) begin
                    next_hh = BCD_12;
                    next_pm = ~pm;
                end else begin
                    next_hh = bcd_inc(hh);
                end
            end
            FIELD_MM: next_mm = (mm == BCD_59) ? BCD_00 : bcd_inc(mm);
            default: ;
        endcase
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set and tick controller: 1 s tick in RUN, button-driven hour/minute edit
// with auto-repeat and blinking, committed to the clock with a one-cycle load strobe.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV     = 50000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int BLINK_DIV    = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [7:0]  cur_hh,
    input  logic [7:0]  cur_mm,
    input  logic        cur_pm,
    output logic        tick_ena,
    output logic        load,
    output logic [7:0]  load_hh,
    output logic [7:0]  load_mm,
    output logic        load_pm,
    output logic [1:0]  edit_field,
    output logic        blank_hh,
    output logic        blank_mm,
    output logic        busy
);

    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [REP_W-1:0]   REP_DELAY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]   REP_RATE   = REP_W'(REPEAT_RATE);
    localparam logic [REP_W-1:0]   REP_ONE    = REP_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    state_t               state;
    logic                 mode_prev;
    logic                 inc_prev;
    logic                 mode_rise;
    logic                 inc_rise;
    logic                 in_edit;
    logic                 repeat_due;
    logic                 do_step;
    logic [TICK_W-1:0]    presc;
    logic [REP_W-1:0]     rep_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink_phase;
    logic [7:0]           edit_hh;
    logic [7:0]           edit_mm;
    logic                 edit_pm;
    logic [7:0]           step_hh;
    logic [7:0]           step_mm;
    logic                 step_pm;
    field_t               step_field;

    assign mode_rise  = btn_mode & ~mode_prev;
    assign inc_rise   = btn_inc & ~inc_prev;
    assign in_edit    = (state == S_EDIT_HH) || (state == S_EDIT_MM);
    // The repeat step fires on the edge where the countdown would reach zero.
    assign repeat_due = btn_inc && (rep_cnt == REP_ONE);
    assign do_step    = in_edit && !mode_rise && (inc_rise || repeat_due);

    always_comb begin
        step_field = FIELD_HH;
        if (state == S_EDIT_MM) step_field = FIELD_MM;
    end

    bcd_time_step u_step (
        .field   (step_field),
        .hh      (edit_hh),
        .mm      (edit_mm),
        .pm      (edit_pm),
        .next_hh (step_hh),
        .next_mm (step_mm),
        .next_pm (step_pm)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != S_RUN || presc == TICK_LAST) presc <= '0;
        else                                                presc <= presc + 1'b1;
    end

    assign tick_ena = (state == S_RUN) && (presc == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || !in_edit || mode_rise || !btn_inc) rep_cnt <= '0;
        else if (inc_rise)                              rep_cnt <= REP_DELAY;
        else if (repeat_due)                            rep_cnt <= REP_RATE;
        else if (rep_cnt != '0)                         rep_cnt <= rep_cnt - 1'b1;
    end

    // Any step restarts the blink so the changed digits are visible immediately.
    always_ff @(posedge clk) begin
        if (reset || !in_edit || mode_rise || do_step) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign blank_hh = (state == S_EDIT_HH) && blink_phase;
    assign blank_mm = (state == S_EDIT_MM) && blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_hh <= BCD_12;
            edit_mm <= BCD_00;
            edit_pm <= 1'b0;
        end else if (state == S_CAPTURE) begin
            edit_hh <= cur_hh;
            edit_mm <= cur_mm;
            edit_pm <= cur_pm;
        end else if (do_step) begin
            edit_hh <= step_hh;
            edit_mm <= step_mm;
            edit_pm <= step_pm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            load       <= 1'b0;
            load_hh    <= BCD_12;
            load_mm    <= BCD_00;
            load_pm    <= 1'b0;
            edit_field <= FIELD_NONE;
            busy       <= 1'b0;
        end else begin
            load <= 1'b0;
            unique case (state)
                S_RUN: begin
                    if (mode_rise) begin
                        state <= S_CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state      <= S_EDIT_HH;
                    edit_field <= FIELD_HH;
                end
                S_EDIT_HH: begin
                    if (mode_rise) begin
                        state      <= S_EDIT_MM;
                        edit_field <= FIELD_MM;
                    end
                end
                S_EDIT_MM: begin
                    if (mode_rise) begin
                        state      <= S_COMMIT;
                        edit_field <= FIELD_NONE;
                        load       <= 1'b1;
                        load_hh    <= edit_hh;
                        load_mm    <= edit_mm;
                        load_pm    <= edit_pm;
                    end
                end
                S_COMMIT: begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_RUN;
                    edit_field <= FIELD_NONE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl against an integer-arithmetic model of
// the edit/tick behaviour, with directed scenarios and randomized button traffic.
module tb_clock_set_ctrl;

    localparam int TICK_DIV     = 10;
    localparam int REPEAT_DELAY = 8;
    localparam int REPEAT_RATE  = 4;
    localparam int BLINK_DIV    = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] cur_hh = 8'h12;
    logic [7:0] cur_mm = 8'h00;
    logic       cur_pm = 1'b0;
    logic       tick_ena;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic       load_pm;
    logic [1:0] edit_field;
    logic       blank_hh;
    logic       blank_mm;
    logic       busy;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hh     (cur_hh),
        .cur_mm     (cur_mm),
        .cur_pm     (cur_pm),
        .tick_ena   (tick_ena),
        .load       (load),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .load_pm    (load_pm),
        .edit_field (edit_field),
        .blank_hh   (blank_hh),
        .blank_mm   (blank_mm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: mode 0=run 1=capture 2=hours 3=minutes 4=commit; times as plain integers.
    int m_mode, m_h, m_m, m_pm, m_lh, m_lm, m_lpm, m_load;
    int m_run_n, m_blink_n, m_hold;
    bit m_armed, m_prev_mode, m_prev_inc;

    function automatic logic [7:0] int2bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_load = 0; m_lh = 12; m_lm = 0; m_lpm = 0;
        m_h = 12; m_m = 0; m_pm = 0;
        m_run_n = 1; m_blink_n = 1; m_hold = 0;
        m_armed = 0; m_prev_mode = 0; m_prev_inc = 0;
    endtask

    task automatic model_update();
        bit mr, ir, step;
        int old;
        if (reset) begin
            model_reset();
            return;
        end
        mr = btn_mode && !m_prev_mode;
        ir = btn_inc && !m_prev_inc;
        m_prev_mode = btn_mode;
        m_prev_inc  = btn_inc;
        old = m_mode;
        step = 0;
        m_load = 0;
        if ((m_mode == 2 || m_mode == 3) && !mr && btn_inc) begin
            if (ir) begin
                step = 1; m_armed = 1; m_hold = 0;
            end else if (m_armed) begin
                m_hold++;
                step = (m_hold >= REPEAT_DELAY) && ((m_hold - REPEAT_DELAY) % REPEAT_RATE == 0);
            end
        end else begin
            m_armed = 0;
        end
        if (step && m_mode == 2) begin
            m_h = m_h % 12 + 1;
            if (m_h == 12) m_pm = 1 - m_pm;
        end
        if (step && m_mode == 3) m_m = (m_m + 1) % 60;
        case (m_mode)
            0: if (mr) m_mode = 1;
            1: begin
                m_h = bcd2int(cur_hh); m_m = bcd2int(cur_mm); m_pm = int'(cur_pm);
                m_mode = 2;
            end
            2: if (mr) m_mode = 3;
            3: if (mr) begin
                m_mode = 4; m_load = 1; m_lh = m_h; m_lm = m_m; m_lpm = m_pm;
            end
            default: m_mode = 0;
        endcase
        m_run_n   = (m_mode == 0 && old == 0) ? m_run_n + 1 : 1;
        m_blink_n = ((m_mode == 2 || m_mode == 3) && old == m_mode && !step) ? m_blink_n + 1 : 1;
    endtask

    function automatic logic [23:0] exp_vec();
        logic t, bh, bm;
        logic [1:0] ef;
        t  = (m_mode == 0) && (m_run_n % TICK_DIV == 0);
        ef = (m_mode == 2) ? 2'd1 : (m_mode == 3) ? 2'd2 : 2'd0;
        bh = (m_mode == 2) && (((m_blink_n - 1) / BLINK_DIV) % 2 == 1);
        bm = (m_mode == 3) && (((m_blink_n - 1) / BLINK_DIV) % 2 == 1);
        return {t, m_load[0], int2bcd(m_lh), int2bcd(m_lm), m_lpm[0], ef, bh, bm, m_mode != 0};
    endfunction

    function automatic logic [23:0] act_vec();
        return {tick_ena, load, load_hh, load_mm, load_pm, edit_field, blank_hh, blank_mm, busy};
    endfunction

    // One clock: model follows the edge, outputs are then read at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [23:0] want;
        want = {2'b00, 8'h12, 8'h00, 6'b000000};
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (3) cycle();
        total++;
        if (act_vec() !== want) begin
            bad++; $display("FAIL reset_state got=%h want=%h", act_vec(), want);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick_run();
        int ticks[$];
        for (int k = 1; k <= 35; k++) begin
            cycle();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL tick_run cyc=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            if (tick_ena) ticks.push_back(k + 1);
        end
        total++;
        if (ticks.size() != 3) begin
            bad++; $display("FAIL tick_count got=%0d want=3", ticks.size());
        end
        foreach (ticks[i]) begin
            total++;
            if (ticks[i] != TICK_DIV * (i + 1)) begin
                bad++; $display("FAIL tick_pos[%0d] got=%0d want=%0d", i, ticks[i], TICK_DIV * (i + 1));
            end
        end
    endtask

    task automatic test_commit();
        int code[8] = '{2, 0, 1, 0, 2, 0, 2, 0};
        int len[8]  = '{2, 2, 2, 2, 2, 2, 2, 14};
        int loads = 0, since_run = 0, gap = 0, cyc = 0;
        cur_hh = 8'h11; cur_mm = 8'h59; cur_pm = 1'b0;
        foreach (code[s]) begin
            btn_mode = code[s][1]; btn_inc = code[s][0];
            repeat (len[s]) begin
                cycle(); cyc++;
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++; $display("FAIL commit cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
                end
                if (load) begin
                    loads++;
                    total++;
                    if ({load_hh, load_mm, load_pm} !== {8'h12, 8'h59, 1'b1}) begin
                        bad++; $display("FAIL commit_value got=%h:%h pm=%b want=12:59 pm=1", load_hh, load_mm, load_pm);
                    end
                end
                if (loads > 0 && !busy) begin
                    since_run++;
                    if (tick_ena && gap == 0) gap = since_run;
                end
            end
        end
        total++;
        if (loads != 1) begin
            bad++; $display("FAIL commit_load_count got=%0d want=1", loads);
        end
        total++;
        if (gap != TICK_DIV) begin
            bad++; $display("FAIL commit_first_tick got=%0d want=%0d", gap, TICK_DIV);
        end
    endtask

    task automatic test_repeat();
        int code[8] = '{2, 0, 2, 0, 1, 0, 2, 0};
        int len[8]  = '{2, 2, 2, 2, 20, 3, 2, 4};
        int loads = 0, cyc = 0;
        cur_hh = 8'h03; cur_mm = 8'h58; cur_pm = 1'b1;
        foreach (code[s]) begin
            btn_mode = code[s][1]; btn_inc = code[s][0];
            repeat (len[s]) begin
                cycle(); cyc++;
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++; $display("FAIL repeat cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
                end
                if (load) begin
                    loads++;
                    total++;
                    if ({load_hh, load_mm, load_pm} !== {8'h03, 8'h02, 1'b1}) begin
                        bad++; $display("FAIL repeat_value got=%h:%h pm=%b want=03:02 pm=1", load_hh, load_mm, load_pm);
                    end
                end
            end
        end
        total++;
        if (loads != 1) begin
            bad++; $display("FAIL repeat_load_count got=%0d want=1", loads);
        end
    endtask

    task automatic test_hours_blink();
        int code[10] = '{2, 0, 1, 0, 1, 0, 2, 0, 2, 0};
        int len[10]  = '{2, 2, 1, 3, 1, 14, 2, 2, 2, 3};
        int loads = 0, cyc = 0, j;
        cur_hh = 8'h12; cur_mm = 8'h30; cur_pm = 1'b1;
        foreach (code[s]) begin
            btn_mode = code[s][1]; btn_inc = code[s][0];
            j = 0;
            repeat (len[s]) begin
                cycle(); cyc++;
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++; $display("FAIL hours cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
                end
                if (s == 2 || s == 4) begin
                    total++;
                    if (blank_hh !== 1'b0) begin
                        bad++; $display("FAIL blank_after_step cyc=%0d got=%b want=0", cyc, blank_hh);
                    end
                end
                if (s == 5) begin
                    total++;
                    if (blank_hh !== (j >= 4 && j <= 8)) begin
                        bad++; $display("FAIL blink_phase j=%0d got=%b want=%b", j, blank_hh, (j >= 4 && j <= 8));
                    end
                end
                if (edit_field != 2'd2 && blank_mm !== 1'b0) begin
                    total++; bad++; $display("FAIL blank_mm_idle cyc=%0d got=%b want=0", cyc, blank_mm);
                end
                if (load) begin
                    loads++;
                    total++;
                    if ({load_hh, load_mm, load_pm} !== {8'h02, 8'h30, 1'b1}) begin
                        bad++; $display("FAIL hours_value got=%h:%h pm=%b want=02:30 pm=1", load_hh, load_mm, load_pm);
                    end
                end
                j++;
            end
        end
        total++;
        if (loads != 1) begin
            bad++; $display("FAIL hours_load_count got=%0d want=1", loads);
        end
    endtask

    task automatic test_simultaneous();
        int code[6] = '{2, 0, 3, 0, 2, 0};
        int len[6]  = '{2, 2, 12, 2, 2, 3};
        int loads = 0, cyc = 0, j;
        cur_hh = 8'h05; cur_mm = 8'h10; cur_pm = 1'b0;
        foreach (code[s]) begin
            btn_mode = code[s][1]; btn_inc = code[s][0];
            j = 0;
            repeat (len[s]) begin
                cycle(); cyc++;
                total++;
                if (act_vec() !== exp_vec()) begin
                    bad++; $display("FAIL simul cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
                end
                if (s == 2 && j == 0) begin
                    total++;
                    if (edit_field !== 2'd2) begin
                        bad++; $display("FAIL simul_field got=%0d want=2", edit_field);
                    end
                end
                if (load) begin
                    loads++;
                    total++;
                    if ({load_hh, load_mm, load_pm} !== {8'h05, 8'h10, 1'b0}) begin
                        bad++; $display("FAIL simul_value got=%h:%h pm=%b want=05:10 pm=0", load_hh, load_mm, load_pm);
                    end
                end
                j++;
            end
        end
        total++;
        if (loads != 1) begin
            bad++; $display("FAIL simul_load_count got=%0d want=1", loads);
        end
    endtask

    task automatic test_reset_in_edit();
        int code[4] = '{2, 0, 2, 0};
        int len[4]  = '{2, 2, 2, 2};
        int first_tick = 0;
        logic [23:0] want;
        want = {2'b00, 8'h12, 8'h00, 6'b000000};
        cur_hh = 8'h07; cur_mm = 8'h45; cur_pm = 1'b0;
        foreach (code[s]) begin
            btn_mode = code[s][1]; btn_inc = code[s][0];
            repeat (len[s]) cycle();
        end
        total++;
        if (edit_field !== 2'd2) begin
            bad++; $display("FAIL pre_reset_field got=%0d want=2", edit_field);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++;
        if (act_vec() !== want) begin
            bad++; $display("FAIL reset_in_edit got=%h want=%h", act_vec(), want);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL post_reset cyc=%0d got=%h want=%h", k, act_vec(), exp_vec());
            end
            if (tick_ena && first_tick == 0) first_tick = k + 1;
        end
        total++;
        if (first_tick != TICK_DIV) begin
            bad++; $display("FAIL post_reset_tick got=%0d want=%0d", first_tick, TICK_DIV);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0)  btn_mode = ~btn_mode;
            if ($urandom_range(0, 11) == 0) btn_inc  = ~btn_inc;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cur_hh = int2bcd($urandom_range(1, 12));
                cur_mm = int2bcd($urandom_range(0, 59));
                cur_pm = 1'($urandom_range(0, 1));
            end
            cycle();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tick_run();
        test_commit();
        test_repeat();
        test_hours_blink();
        test_simultaneous();
        test_reset_in_edit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
